// File: rtl/mips_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble encoding and
// the hard-wired zero register index.
package mips_pkg;

  localparam int CTRL_W     = 12;
  localparam int CTRL_REGWR = 0;
  localparam int CTRL_MEMRD = 1;
  localparam int CTRL_MEMWR = 2;
  localparam int CTRL_NOP   = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles and
// saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ID_PC,
  input  logic [DATA_W-1:0] ID_BusA,
  input  logic [DATA_W-1:0] ID_BusB,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic [4:0]        ID_Rd,
  input  logic              ID_UsesRt,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic              Flush,
  output logic [DATA_W-1:0] ID_EX_PC,
  output logic [DATA_W-1:0] ID_EX_BusA,
  output logic [DATA_W-1:0] ID_EX_BusB,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              ID_EX_RegWr,
  output logic              ID_EX_Valid,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(mips_pkg::CTRL_NOP);

  logic hazard;
  logic bubble;
  logic stall_event;

  // A load in EX whose destination is read by the instruction in ID.
  assign hazard = ID_EX_Ctrl[mips_pkg::CTRL_MEMRD] & ID_EX_Valid &
                  (ID_EX_Rt != mips_pkg::REG_ZERO) &
                  ((ID_EX_Rt == ID_Rs) | (ID_UsesRt & (ID_EX_Rt == ID_Rt)));

  assign bubble      = Flush | hazard;
  assign stall_event = hazard & ~Flush;
  assign Stall       = stall_event & reset;
  assign ID_EX_RegWr = ID_EX_Ctrl[mips_pkg::CTRL_REGWR];

  // Bubbles zero every field so forwarding compares never match them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ID_EX_PC    <= '0;
      ID_EX_BusA  <= '0;
      ID_EX_BusB  <= '0;
      ID_EX_Imm   <= '0;
      ID_EX_Rs    <= mips_pkg::REG_ZERO;
      ID_EX_Rt    <= mips_pkg::REG_ZERO;
      ID_EX_Rd    <= mips_pkg::REG_ZERO;
      ID_EX_Ctrl  <= BUBBLE_CTRL;
      ID_EX_Valid <= 1'b0;
    end else if (bubble) begin
      ID_EX_PC    <= '0;
      ID_EX_BusA  <= '0;
      ID_EX_BusB  <= '0;
      ID_EX_Imm   <= '0;
      ID_EX_Rs    <= mips_pkg::REG_ZERO;
      ID_EX_Rt    <= mips_pkg::REG_ZERO;
      ID_EX_Rd    <= mips_pkg::REG_ZERO;
      ID_EX_Ctrl  <= BUBBLE_CTRL;
      ID_EX_Valid <= 1'b0;
    end else begin
      ID_EX_PC    <= ID_PC;
      ID_EX_BusA  <= ID_BusA;
      ID_EX_BusB  <= ID_BusB;
      ID_EX_Imm   <= ID_Imm;
      ID_EX_Rs    <= ID_Rs;
      ID_EX_Rt    <= ID_Rt;
      ID_EX_Rd    <= ID_Rd;
      ID_EX_Ctrl  <= ID_Ctrl;
      ID_EX_Valid <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_n (reset),
    .inc     (stall_event),
    .count   (StallCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_n (reset),
    .inc     (Flush),
    .count   (FlushCnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, $zero, flush priority,
// counter saturation and asynchronous reset.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] ID_PC, ID_BusA, ID_BusB, ID_Imm;
  logic [4:0]        ID_Rs, ID_Rt, ID_Rd;
  logic              ID_UsesRt;
  logic [CTRL_W-1:0] ID_Ctrl;
  logic              Flush;
  logic [DATA_W-1:0] ID_EX_PC, ID_EX_BusA, ID_EX_BusB, ID_EX_Imm;
  logic [4:0]        ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [CTRL_W-1:0] ID_EX_Ctrl;
  logic              ID_EX_RegWr, ID_EX_Valid, Stall;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ID_PC(ID_PC), .ID_BusA(ID_BusA), .ID_BusB(ID_BusB), .ID_Imm(ID_Imm),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_UsesRt(ID_UsesRt),
    .ID_Ctrl(ID_Ctrl), .Flush(Flush),
    .ID_EX_PC(ID_EX_PC), .ID_EX_BusA(ID_EX_BusA), .ID_EX_BusB(ID_EX_BusB),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_RegWr(ID_EX_RegWr),
    .ID_EX_Valid(ID_EX_Valid), .Stall(Stall),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input logic [63:0] observed,
                     input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic uses_rt, input logic [CTRL_W-1:0] ctrl,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_UsesRt = uses_rt; ID_Ctrl = ctrl;
    ID_BusA = a; ID_BusB = b; ID_PC = ID_PC + 32'd4; ID_Imm = 32'h10;
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b0; Flush = 1'b1;
    ID_PC = $urandom; ID_BusA = $urandom; ID_BusB = $urandom; ID_Imm = $urandom;
    ID_Rs = 5'($urandom); ID_Rt = 5'($urandom); ID_Rd = 5'($urandom);
    ID_UsesRt = 1'b1; ID_Ctrl = 12'hFFF;
    repeat (3) step();
    chk("rst_pc", ID_EX_PC, 0);
    chk("rst_busa", ID_EX_BusA, 0);
    chk("rst_rd", ID_EX_Rd, 0);
    chk("rst_ctrl", ID_EX_Ctrl, 0);
    chk("rst_valid", ID_EX_Valid, 0);
    chk("rst_stall", Stall, 0);
    chk("rst_cnts", {StallCnt, FlushCnt}, 0);

    // add $3,$1,$2
    Flush = 1'b0; ID_PC = 32'h100;
    reset = 1'b1;
    drive(5'd1, 5'd2, 5'd3, 1'b1, 12'h001, 32'd11, 32'd22);
    step();
    chk("add_rd", ID_EX_Rd, 3);
    chk("add_regwr", ID_EX_RegWr, 1);
    chk("add_valid", ID_EX_Valid, 1);
    chk("add_busa", ID_EX_BusA, 11);
    chk("add_pc", ID_EX_PC, 32'h104);

    // lw $5 followed by a consumer of $5 through Rs
    drive(5'd1, 5'd5, 5'd5, 1'b0, 12'h003, 32'd7, 32'd0);
    step();
    chk("lw_ctrl", ID_EX_Ctrl, 12'h003);
    drive(5'd5, 5'd2, 5'd6, 1'b1, 12'h001, 32'd33, 32'd44);
    #1 chk("lu_stall", Stall, 1);
    step();
    chk("lu_bub_valid", ID_EX_Valid, 0);
    chk("lu_bub_ctrl", ID_EX_Ctrl, 0);
    chk("lu_bub_rd", ID_EX_Rd, 0);
    chk("lu_bub_busa", ID_EX_BusA, 0);
    chk("lu_stallcnt", StallCnt, 1);
    chk("lu_stall_drop", Stall, 0);
    step();
    chk("lu_cons_valid", ID_EX_Valid, 1);
    chk("lu_cons_rs", ID_EX_Rs, 5);
    chk("lu_cons_rd", ID_EX_Rd, 6);
    chk("lu_cons_busa", ID_EX_BusA, 33);

    // Rt-only dependency gated by ID_UsesRt
    drive(5'd1, 5'd7, 5'd7, 1'b0, 12'h003, 32'd0, 32'd0);
    step();
    drive(5'd3, 5'd7, 5'd8, 1'b0, 12'h001, 32'd0, 32'd0);
    #1 chk("rt_nouse_stall", Stall, 0);
    ID_UsesRt = 1'b1;
    #1 chk("rt_use_stall", Stall, 1);
    step();
    chk("rt_bub_valid", ID_EX_Valid, 0);
    chk("rt_stallcnt", StallCnt, 2);
    step();
    chk("rt_cons_rd", ID_EX_Rd, 8);

    // Load into $zero never stalls
    drive(5'd1, 5'd0, 5'd0, 1'b0, 12'h003, 32'd0, 32'd0);
    step();
    drive(5'd0, 5'd0, 5'd9, 1'b1, 12'h001, 32'd0, 32'd0);
    #1 chk("zero_stall", Stall, 0);
    step();
    chk("zero_valid", ID_EX_Valid, 1);
    chk("zero_rd", ID_EX_Rd, 9);
    chk("zero_stallcnt", StallCnt, 2);

    // Flush overrides a simultaneous load-use hazard
    drive(5'd1, 5'd5, 5'd5, 1'b0, 12'h003, 32'd0, 32'd0);
    step();
    drive(5'd5, 5'd2, 5'd6, 1'b1, 12'h001, 32'd0, 32'd0);
    Flush = 1'b1;
    #1 chk("fl_stall", Stall, 0);
    step();
    Flush = 1'b0;
    chk("fl_valid", ID_EX_Valid, 0);
    chk("fl_ctrl", ID_EX_Ctrl, 0);
    chk("fl_flushcnt", FlushCnt, 1);
    chk("fl_stallcnt", StallCnt, 2);

    // Reset asserted while Stall is high
    drive(5'd1, 5'd5, 5'd5, 1'b0, 12'h003, 32'd0, 32'd0);
    step();
    drive(5'd5, 5'd2, 5'd6, 1'b1, 12'h001, 32'd0, 32'd0);
    #1 chk("mid_pre_stall", Stall, 1);
    reset = 1'b0;
    #1 chk("mid_stall", Stall, 0);
    chk("mid_valid", ID_EX_Valid, 0);
    chk("mid_ctrl", ID_EX_Ctrl, 0);
    chk("mid_flushcnt", FlushCnt, 0);
    step();
    reset = 1'b1;

    // Flush counter saturation
    Flush = 1'b1;
    repeat ((1 << CNT_W) - 1) @(posedge clk);
    #1 chk("sat_reach", FlushCnt, 16'hFFFF);
    repeat (4) @(posedge clk);
    #1 chk("sat_hold", FlushCnt, 16'hFFFF);
    chk("sat_stallcnt", StallCnt, 0);
    #2 reset = 1'b0;
    #1 chk("sat_async_clr", FlushCnt, 0);
    chk("sat_async_stall", StallCnt, 0);
    Flush = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection and branch-flush bubble insertion. Captures decoded ID-stage operands and controls each cycle. Presents ID_EX_Rs/ID_EX_Rt/ID_EX_Rd and RegWr to the EX-stage operand-forwarding logic. Drives Stall back to the PC and the IF/ID register. Keeps saturating stall and flush event counters for performance debug.

Parameters:
DATA_W, 32, datapath width (PC, operands, immediate)
CTRL_W, 12, width of packed control bundle; bit0 RegWr, bit1 MemRd, bit2 MemWr, upper bits opaque EX/MEM/WB controls
CNT_W, 16, width of stall/flush event counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_PC  in  DATA_W  PC+4 of ID instruction
ID_BusA  in  DATA_W  register-file read A
ID_BusB  in  DATA_W  register-file read B
ID_Imm  in  DATA_W  extended immediate
ID_Rs  in  5  source register 1
ID_Rt  in  5  source register 2
ID_Rd  in  5  resolved write-destination register (RegDst already applied)
ID_UsesRt  in  1  instruction reads Rt as a source
ID_Ctrl  in  CTRL_W  packed controls
Flush  in  1  branch/jump taken resolved in EX; kill ID instruction
ID_EX_PC / ID_EX_BusA / ID_EX_BusB / ID_EX_Imm  out  DATA_W  registered copies
ID_EX_Rs / ID_EX_Rt / ID_EX_Rd  out  5  registered register indices
ID_EX_Ctrl  out  CTRL_W  registered controls
ID_EX_RegWr  out  1  alias of ID_EX_Ctrl[0]
ID_EX_Valid  out  1  0 = bubble in EX
Stall  out  1  hold PC and IF/ID this cycle (combinational)
StallCnt  out  CNT_W  load-use bubbles inserted
FlushCnt  out  CNT_W  flush bubbles inserted

Behaviour:
- Reset (reset=0, async): all registered outputs, counters and Valid = 0. Stall reads 0 while in reset.
- Hazard (combinational) = ID_EX_Ctrl[1] & ID_EX_Valid & (ID_EX_Rt != 0) & ((ID_EX_Rt == ID_Rs) | (ID_UsesRt & (ID_EX_Rt == ID_Rt))).
- Stall = Hazard & ~Flush. Flush overrides because the ID instruction is wrong-path.
- Per rising edge, priority order:
  1) Flush=1: load a bubble. All ID_EX_Ctrl = 0, Valid = 0, Rs/Rt/Rd = 0, data fields = 0. FlushCnt += 1 (saturating).
  2) Else Hazard=1: load a bubble (same values). StallCnt += 1 (saturating).
  3) Else: capture all ID_* inputs. Valid = 1.
- Bubble index fields = 0 so the forwarding compare (Rd != 0) never matches a bubble.
- Latency: exactly one cycle ID->EX. A load-use pair costs exactly one bubble: on the next cycle the load has left ID/EX, Hazard deasserts, and the held consumer enters.
- Back-to-back hazards are not possible (a bubble has MemRd = 0). Stall never asserts two consecutive cycles for one pair.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall: Stall drops immediately. Registers clear asynchronously.
- No X propagation: uninitialised ID inputs during a bubble are not captured.

Decomposition:
- Shared package mips_pkg: CTRL_W, control-bit indices (CTRL_REGWR=0, CTRL_MEMRD=1, CTRL_MEMWR=2), bubble constant CTRL_NOP = 0, REG_ZERO = 5'd0.
- One sub-module sat_counter (width CNT_W, inc, async active-low clear), instantiated twice for StallCnt and FlushCnt.
- Hazard compare stays inline.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0, Stall=0. Release, drive add $3,$1,$2 (Ctrl RegWr=1) -> next cycle ID_EX_Rd=3, ID_EX_RegWr=1, Valid=1.
- Load-use: lw $5 in ID/EX (MemRd=1, Rt=5); ID has Rs=5 -> Stall=1 same cycle. Next edge: Valid=0, Ctrl=0, StallCnt=1. Following cycle: Stall=0, consumer captured with Rs=5.
- Rt-only dependency: lw Rt=7, ID Rt=7, ID_UsesRt=0 -> Stall=0. Same with ID_UsesRt=1 -> Stall=1.
- $zero: lw Rt=0, ID Rs=0 -> Stall=0, no bubble, StallCnt unchanged.
- Flush with hazard: load-use condition plus Flush=1 -> Stall=0, bubble inserted, FlushCnt+1, StallCnt unchanged.
- Saturation: preload via 2^CNT_W+3 flushes -> FlushCnt = all-ones. Async reset mid-cycle -> counters 0 before the next edge.
